// File: rtl/seven_seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl_pkg
// Shared types and defaults for the 7-segment digit-scan controller:
//   scan_state_e  - scan FSM state encoding (ST_BLANK is used only when the
//                   SEG_BLANK_EN macro is defined)
//   DEF_*         - default parameter values for the 6-digit display
//   max_u         - elaboration-time helper for counter sizing
// ---------------------------------------------------------------------------
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    localparam int unsigned DEF_NUM_DIGITS   = 6;
    localparam int unsigned DEF_SEL_W        = 3;
    localparam int unsigned DEF_PRESCALE     = 50000;
    localparam int unsigned DEF_BLANK_CYCLES = 500;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// ---------------------------------------------------------------------------
// seven_seg_prescaler
// Modulo-N interval counter. Counts 0..last_i while en_i is high, wraps to 0
// after last_i, and is forced to 0 by clr_i. The modulus is a run-time input
// so one instance can time intervals of different lengths.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - synchronous clear to 0 (priority over counting)
//   en_i      - count enable
//   last_i    - terminal count value (N-1)
//   tc_c_o    - combinational terminal-count flag (count == last_i while enabled)
// ---------------------------------------------------------------------------
module seven_seg_prescaler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c_o = en_i && (cnt_q == last_i);

    // Next count: clear wins, terminal count wraps, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tc_c_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Digit-scan controller for a multiplexed 7-segment display. Walks the digits
// enabled in digit_mask, showing each for PRESCALE cycles, drives the
// downstream mux select and one-hot anode enables (all registered), and
// pulses frame_tick when the scan wraps back to the lowest enabled digit.
// Optional macro SEG_BLANK_EN inserts BLANK_CYCLES dark cycles between digits,
// with mux_sel changing at the start of the dark gap (anti-ghosting).
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en          - scan enable; low forces IDLE
//   digit_mask  - bit i includes digit i in the scan
//   mux_sel     - registered digit index to the segment mux
//   an          - registered one-hot anode enables (polarity per ANODE_ACTIVE_LOW)
//   frame_tick  - registered 1-cycle pulse on a scan wrap
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = DEF_NUM_DIGITS,
    parameter int unsigned SEL_W            = DEF_SEL_W,
    parameter int unsigned PRESCALE         = DEF_PRESCALE,
    parameter int unsigned BLANK_CYCLES     = DEF_BLANK_CYCLES,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      mux_sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

`ifdef SEG_BLANK_EN
    localparam int unsigned CNT_MAX = max_u(PRESCALE, BLANK_CYCLES);
`else
    localparam int unsigned CNT_MAX = PRESCALE;
`endif
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    // Parameter sanity checks at elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_chk_digits
        $error("NUM_DIGITS must be 1..8");
    end
    if (PRESCALE < 2) begin : g_chk_prescale
        $error("PRESCALE must be >= 2");
    end
    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("BLANK_CYCLES must be >= 1");
    end

    scan_state_e           state_q, state_d;
    logic [SEL_W-1:0]      mux_sel_q, mux_sel_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  run_c;
    logic                  tc_c;
    logic [CNT_W-1:0]      last_c;
    logic [SEL_W-1:0]      first_c;
    logic [SEL_W-1:0]      next_c;
    logic                  cur_on_c;

    // Lowest set mask bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Next set mask bit strictly above cur, wrapping to the lowest set bit.
    // With a single enabled digit this returns that digit again.
    function automatic logic [SEL_W-1:0] next_digit(input logic [NUM_DIGITS-1:0] mask,
                                                    input logic [SEL_W-1:0]      cur);
        logic [SEL_W-1:0] above;
        logic             found;
        above = '0;
        found = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) > cur)) begin
                above = SEL_W'(i);
                found = 1'b1;
            end
        end
        return found ? above : lowest_set(mask);
    endfunction

    function automatic logic mask_bit(input logic [NUM_DIGITS-1:0] mask,
                                      input logic [SEL_W-1:0]      idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (SEL_W'(i) == idx) b = mask[i];
        end
        return b;
    endfunction

    // Anode vector with digit idx lit when on=1, in the configured polarity.
    function automatic logic [NUM_DIGITS-1:0] anode(input logic [SEL_W-1:0] idx,
                                                    input logic             on);
        logic [NUM_DIGITS-1:0] hot;
        hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (on && (SEL_W'(i) == idx)) hot[i] = 1'b1;
        end
        return ANODE_ACTIVE_LOW ? ~hot : hot;
    endfunction

    assign run_c    = en && (digit_mask != '0);
    assign first_c  = lowest_set(digit_mask);
    assign next_c   = next_digit(digit_mask, mux_sel_q);
    assign cur_on_c = mask_bit(digit_mask, mux_sel_q);

`ifdef SEG_BLANK_EN
    assign last_c = (state_q == ST_BLANK) ? CNT_W'(BLANK_CYCLES - 1) : CNT_W'(PRESCALE - 1);
`else
    assign last_c = CNT_W'(PRESCALE - 1);
`endif

    // Shared interval timer: SHOW period and (optionally) BLANK gap.
    seven_seg_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr_i  ((state_q == ST_IDLE) || !run_c),
        .en_i   (state_q != ST_IDLE),
        .last_i (last_c),
        .tc_c_o (tc_c)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= '0;
            an_q      <= AN_OFF;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!run_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SHOW;
`ifdef SEG_BLANK_EN
                ST_SHOW:  if (tc_c) state_d = ST_BLANK;
                ST_BLANK: if (tc_c) state_d = ST_SHOW;
`else
                ST_SHOW: state_d = ST_SHOW;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output next values; an follows the live mask so a cleared digit darkens at once.
    always_comb begin
        mux_sel_d = mux_sel_q;
        an_d      = AN_OFF;
        tick_d    = 1'b0;
        if (run_c) begin
            case (state_q)
                ST_IDLE: begin
                    mux_sel_d = first_c;
                    an_d      = anode(first_c, 1'b1);
                end
                ST_SHOW: begin
                    if (tc_c) begin
                        mux_sel_d = next_c;
                        tick_d    = (next_c <= mux_sel_q);
`ifdef SEG_BLANK_EN
                        an_d      = AN_OFF;
`else
                        an_d      = anode(next_c, 1'b1);
`endif
                    end else begin
                        an_d = anode(mux_sel_q, cur_on_c);
                    end
                end
`ifdef SEG_BLANK_EN
                ST_BLANK: begin
                    if (tc_c) an_d = anode(mux_sel_q, cur_on_c);
                end
`endif
                default: an_d = AN_OFF;
            endcase
        end
    end

    assign mux_sel    = mux_sel_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
// Self-checking bench: directed scenarios plus randomized en/mask/reset
// traffic, compared every cycle against a timeline model of the scan.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int ND = 6;
    localparam int P  = 4;
`ifdef SEG_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int SLOT = P + BL;

    logic          clk;
    logic          rst;
    logic          en;
    logic [ND-1:0] digit_mask;
    logic [2:0]    mux_sel;
    logic [ND-1:0] an;
    logic          frame_tick;

    int n_cmp;
    int n_err;
    int cyc;

    // Reference model: digit slot timeline.
    bit            m_active;
    int            m_sel;
    int            m_age;
    logic [ND-1:0] m_an;
    bit            m_tick;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS       (ND),
        .SEL_W            (3),
        .PRESCALE         (P),
        .BLANK_CYCLES     (2),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .mux_sel    (mux_sel),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [ND-1:0] lit(input int idx);
        logic [ND-1:0] v;
        v = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    function automatic int lowest(input logic [ND-1:0] mask);
        for (int k = 0; k < ND; k++) if (mask[k]) return k;
        return 0;
    endfunction

    function automatic int next_idx(input logic [ND-1:0] mask, input int cur);
        for (int k = 1; k <= ND; k++) if (mask[(cur + k) % ND]) return (cur + k) % ND;
        return cur;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_sel    = 0;
        m_age    = 0;
        m_an     = '1;
        m_tick   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int nx;
        m_tick = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!en || digit_mask == '0) begin
            m_active = 1'b0;
            m_an     = '1;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_sel    = lowest(digit_mask);
            m_age    = 0;
            m_an     = lit(m_sel);
        end else begin
            m_age++;
            if (m_age == P) begin
                nx     = next_idx(digit_mask, m_sel);
                m_tick = (nx <= m_sel);
                m_sel  = nx;
                if (BL == 0) begin
                    m_age = 0;
                    m_an  = lit(m_sel);
                end else begin
                    m_an = '1;
                end
            end else if (m_age == SLOT) begin
                m_age = 0;
                m_an  = digit_mask[m_sel] ? lit(m_sel) : '1;
            end else if (m_age < P) begin
                m_an = digit_mask[m_sel] ? lit(m_sel) : '1;
            end else begin
                m_an = '1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("mux_sel", 32'(mux_sel), 32'(m_sel));
        check("an", 32'(an), 32'(m_an));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    // Asynchronous reset pulse landing mid-cycle; outputs must clear before any edge.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_an", 32'(an), 32'h3F);
        check("rst_sel", 32'(mux_sel), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        step();
        #2;
        rst = 1'b0;
    endtask

    task automatic go_idle();
        en = 1'b0;
        step();
    endtask

    // Run n cycles and require every gap between frame_tick pulses to equal exp_gap.
    task automatic tick_period(input string tag, input int n, input int exp_gap);
        int last;
        int seen;
        last = -1;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (frame_tick === 1'b1) begin
                if (last >= 0) check(tag, 32'(cyc - last), 32'(exp_gap));
                last = cyc;
                seen++;
            end
        end
        check({tag, "_count"}, 32'(seen >= 2), 32'd1);
    endtask

    initial begin
        bit found;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst        = 1'b1;
        en         = 1'b0;
        digit_mask = '0;
        model_reset();
        step();
        step();
        check("reset_an", 32'(an), 32'h3F);
        check("reset_sel", 32'(mux_sel), 32'd0);
        #2;
        rst = 1'b0;

        // Scan start, then reset mid-scan and restart at digit 0.
        en         = 1'b1;
        digit_mask = 6'h3F;
        step();
        check("start_an", 32'(an), 32'h3E);
        repeat (7) step();
        mid_reset();
        step();
        check("restart_sel", 32'(mux_sel), 32'd0);
        check("restart_an", 32'(an), 32'h3E);

        // Full mask: wrap once per six slots.
        tick_period("tick_gap_3f", 6 * SLOT * 2 + 8, 6 * SLOT);

        // Sparse mask 100101.
        go_idle();
        en         = 1'b1;
        digit_mask = 6'b100101;
        tick_period("tick_gap_25", 3 * SLOT * 3 + 4, 3 * SLOT);

        // Single digit: select holds at 3.
        go_idle();
        en         = 1'b1;
        digit_mask = 6'b001000;
        for (int k = 0; k < 3 * SLOT; k++) begin
            step();
            check("single_sel", 32'(mux_sel), 32'd3);
`ifndef SEG_BLANK_EN
            check("single_an", 32'(an), 32'h37);
`endif
        end
        tick_period("tick_gap_08", SLOT * 4, SLOT);

        // Disable on cycle 2 of digit 4, re-enable with mask 6'h30.
        go_idle();
        en         = 1'b1;
        digit_mask = 6'h3F;
        found      = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (m_active && m_sel == 4 && m_age == 1) found = 1'b1;
        end
        check("reach_digit4", 32'(found), 32'd1);
        en = 1'b0;
        step();
        check("dis_an", 32'(an), 32'h3F);
        check("dis_sel_hold", 32'(mux_sel), 32'd4);
        en         = 1'b1;
        digit_mask = 6'h30;
        step();
        check("reen_sel", 32'(mux_sel), 32'd4);
        check("reen_an", 32'(an), 32'h2F);
        repeat (P - 1) step();
        check("reen_full_period", 32'(mux_sel), 32'd4);
        step();
        check("reen_advance", 32'(mux_sel), 32'd5);

        // Two digits; also the blanking case.
        go_idle();
        en         = 1'b1;
        digit_mask = 6'h03;
        tick_period("tick_gap_03", 2 * SLOT * 3 + 4, 2 * SLOT);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) digit_mask = ND'($urandom);
            if ($urandom_range(19) == 0) en = ($urandom_range(3) != 0);
            if ($urandom_range(149) == 0) mid_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
